// File: rtl/onehot_decoder_pkg.sv
// Shared types and sizing helpers for the one-hot pulse decoder.
package onehot_decoder_pkg;

  // Width of the pulse/gap timer and of the accepted-code counter.
  localparam int CNT_W = 8;

  // Controller states: waiting for a code, driving the strobe, enforcing the guard gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One-hot output width for a given binary code width.
  function automatic int onehot_w(input int code_w);
    return 1 << code_w;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_timer.sv
// Loadable down-counter shared by the PULSE and GAP countdowns.
// Load has priority over decrement. The counter holds at zero instead of
// wrapping, so a stray decrement can never restart a countdown.
module dec_timer
  import onehot_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load a new countdown or step the current one toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The FSM only needs to know when the countdown has expired.
  assign zero = (count == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Binary code in over valid/ready, registered one-hot strobe out for
// PULSE_LEN cycles, then a GAP_LEN-cycle guard gap before the next code.
module onehot_pulse_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int CODE_W    = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_W-1:0]             in_code,
  input  logic                          abort,
  output logic [onehot_w(CODE_W)-1:0]   out_onehot,
  output logic                          out_valid,
  output logic                          busy,
  output logic [CNT_W-1:0]              acc_cnt
);

  localparam int OH_W = onehot_w(CODE_W);

  // Timer reload values. The timer counts the remaining cycles minus one,
  // so a value of zero means "this is the last cycle of the phase".
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  // A handshake only counts when abort is low; abort in IDLE vetoes the accept.
  assign accept = in_valid && in_ready && !abort;

  dec_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timer control; abort outranks timer expiry.
  always_comb begin
    // NOTE: every output gets a default first so this block never infers a latch.
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end

      PULSE: begin
        if (abort) begin
          state_d  = IDLE;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (tmr_zero) begin
          if (GAP_LEN == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d  = IDLE;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state only.
  always_comb begin
    in_ready = (state_q == IDLE) && rst_n;
    busy     = (state_q != IDLE);
  end

  // Decode register: capture the code at accept, clear whenever the pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_onehot <= OH_W'(1) << in_code;
      out_valid  <= 1'b1;
    end else if (state_d != PULSE) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end
  end

  // Accepted-code counter; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // The strobe is never more than one-hot, and out_valid tracks it exactly.
  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_onehot));
  a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
                                     out_valid == (out_onehot != '0));
  a_pulse_only_when_busy : assert property (@(posedge clk) disable iff (!rst_n)
                                            out_valid |-> busy);

endmodule
